stage1_seq_ctrl: RTL and testbench
==================================

// Module: stage1_seq_ctrl
// PURPOSE
//  Sequencer for the stage-1 SVM kernel datapath (NUM_OF_SV parallel dot_prod MAC slices).
//  Per classification it clears the MACs and issues one pixel address per cycle to the
//  test-vector and SV RAMs, so that all MACs see the same pixel index. It then waits out
//  the RAM and MAC latency, loads the kernel shift chain and streams NUM_OF_SV results
//  to the decision stage over a valid/ready handshake.
// PARAMETERS
//  NUM_OF_PIXELS  30  pixels per vector = FETCH length
//  NUM_OF_SV      10  support vectors = MAC slices = SHIFT length
//  RAM_LAT        1   cycles from rd_en to pixel data at MAC inputs (>=1)
//  MAC_LAT        3   cycles from last mac_en to final mac_out valid (>=1)
//  ADDR_W         $clog2(NUM_OF_PIXELS)  pixel address width
//  IDX_W          $clog2(NUM_OF_SV)      SV index width
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       request one classification; sampled only in IDLE
//  busy        out  1       high in every state except IDLE
//  rd_en       out  1       RAM read strobe (test and all SV banks)
//  pix_addr    out  ADDR_W  pixel index, shared by all banks
//  mac_clr     out  1       clear all MAC accumulators (1 cycle)
//  mac_en      out  1       accumulate the current pixel product
//  mac_last    out  1       qualifies mac_en for pixel NUM_OF_PIXELS-1
//  shift_load  out  1       capture all kernel_out_sv* into the shift chain
//  shift_en    out  1       advance shift chain by one SV (= k_valid & k_ready)
//  k_valid     out  1       kernel value at chain head is valid
//  k_ready     in   1       downstream accepts the head value
//  k_idx       out  IDX_W   SV index of the head value
//  done        out  1       1-cycle pulse: all NUM_OF_SV values accepted
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; pixel/SV/drain counters and delay line cleared.
//    rst wins over every other input and aborts any state on the next edge.
//  - FSM: IDLE -start-> CLEAR -> FETCH -> DRAIN -> LOAD -> SHIFT -> DONE -> IDLE.
//  - IDLE: start=1 -> CLEAR at the next edge. start is ignored in all other states,
//    which means there is no queuing.
//  - CLEAR (1 cyc): mac_clr=1.
//  - FETCH (NUM_OF_PIXELS cyc): rd_en=1; pix_addr=0,1,..,NUM_OF_PIXELS-1, one step per cycle.
//    The address never wraps inside a job. pix_addr returns to 0 on exit.
//  - mac_en = rd_en delayed RAM_LAT cycles; mac_last = (rd_en & last addr) delayed identically.
//  - DRAIN (RAM_LAT+MAC_LAT cyc): all strobes 0; the down-counter reaches 0 -> LOAD.
//  - LOAD (1 cyc): shift_load=1.
//  - SHIFT: k_valid=1 with k_idx starting at 0. shift_en is combinational k_valid&k_ready.
//    On each accepted value k_idx increments. When k_ready=0, k_idx holds and shift_en=0.
//    After k_idx=NUM_OF_SV-1 is accepted, the next state is DONE.
//  - DONE (1 cyc): done=1, busy=1; then IDLE. The earliest next start is accepted one
//    cycle after DONE.
//  - All outputs except shift_en are registered.
//  - Timing with defaults, start accepted at edge 0 and k_ready=1:
//    CLEAR cyc 1, FETCH 2..31, DRAIN 32..35, LOAD 36, SHIFT 37..46, done at cyc 47.
//  - Exactly NUM_OF_PIXELS mac_en pulses per job and exactly one mac_clr per job.
//    mac_clr never overlaps mac_en.
// STRUCTURE
//  - stage1_pkg holds the state encoding localparams (IDLE..DONE) and the default
//    NUM_OF_PIXELS and NUM_OF_SV constants, shared with stage1_top and the RAM fetch.
//  - Sub-module valid_delay #(DEPTH=RAM_LAT, W=2): a reset-clearable shift register
//    carrying {rd_en, last} -> {mac_en, mac_last}.
//  - FSM, pixel counter, drain counter and SV counter sit in this module.
// TESTING
//  1. Defaults, start pulse, k_ready=1 -> mac_clr at cyc 1; mac_en at cycles 3..32 (30 pulses,
//     mac_last at 32); shift_load at 36; k_idx 0..9 over 37..46; done at 47; busy 1..47.
//  2. k_ready toggles 1,0 during SHIFT -> k_idx holds when ready is low; shift_en exactly 10
//     pulses; done 10 cycles later than in test 1.
//  3. start held high continuously -> jobs repeat; each job is fully spaced; no second mac_clr
//     inside a job; the next CLEAR comes one cycle after the IDLE cycle that follows done.
//  4. rst asserted at cycle 15 (mid-FETCH) with start=1 -> next cycle all outputs 0, IDLE;
//     no late mac_en leaks from the delay line; a fresh start gives the same timing as test 1.
//  5. Parameters NUM_OF_PIXELS=4, NUM_OF_SV=2, RAM_LAT=2, MAC_LAT=1 -> pix_addr 0..3;
//     mac_en lags rd_en by 2 cycles; DRAIN lasts 3 cycles; k_idx 0,1; done follows.
//  6. start and rst high in the same cycle -> state stays IDLE; busy=0.

Source files
------------

// File: rtl/stage1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : stage1_pkg                                                       |
// | Shared constants for the stage-1 SVM kernel datapath: sequencer state      |
// | encoding, default vector geometry and a width helper.                      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package stage1_pkg;

  localparam int NUM_OF_PIXELS_DEF = 30;
  localparam int NUM_OF_SV_DEF     = 10;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CLEAR = 3'd1;
  localparam state_t S_FETCH = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_LOAD  = 3'd4;
  localparam state_t S_SHIFT = 3'd5;
  localparam state_t S_DONE  = 3'd6;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stage1_seq_ctrl_valid_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : valid_delay                                                      |
// | Reset-clearable shift register of DEPTH stages, W bits wide. Used to line  |
// | up the fetch strobes with pixel data arriving from the RAMs.               |
// | Ports   : clk, rst   clock / synchronous active-high reset                 |
// |           d_i [W]    strobe vector in                                      |
// |           q_o [W]    strobe vector delayed by DEPTH cycles                 |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module valid_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [DEPTH-1:0][W-1:0] pipe_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= d_i;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= {pipe_q[DEPTH-2:0], d_i};
      end
    end
  endgenerate

  assign q_o = pipe_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/stage1_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stage1_seq_ctrl                                                  |
// | Sequencer for the stage-1 SVM kernel: clears the MAC slices, fetches one   |
// | pixel per cycle, waits out RAM+MAC latency, loads the kernel shift chain   |
// | and streams NUM_OF_SV results over a valid/ready handshake.                |
// | Ports   : clk, rst              clock / synchronous active-high reset      |
// |           start                 request a classification (IDLE only)       |
// |           busy                  high outside IDLE                          |
// |           rd_en, pix_addr       RAM read strobe and shared pixel index     |
// |           mac_clr/mac_en/last   MAC control, aligned to RAM data           |
// |           shift_load, shift_en  kernel shift-chain control                 |
// |           k_valid, k_ready      handshake for the chain head value         |
// |           k_idx                 SV index of the head value                 |
// |           done                  one-cycle completion pulse                 |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module stage1_seq_ctrl
  import stage1_pkg::*;
#(
  parameter int NUM_OF_PIXELS = NUM_OF_PIXELS_DEF,
  parameter int NUM_OF_SV     = NUM_OF_SV_DEF,
  parameter int RAM_LAT       = 1,
  parameter int MAC_LAT       = 3,
  parameter int ADDR_W        = clog2_min1(NUM_OF_PIXELS),
  parameter int IDX_W         = clog2_min1(NUM_OF_SV)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              mac_last,
  output logic              shift_load,
  output logic              shift_en,
  output logic              k_valid,
  input  logic              k_ready,
  output logic [IDX_W-1:0]  k_idx,
  output logic              done
);

  localparam int DRAIN_CYC = RAM_LAT + MAC_LAT;
  localparam int DRAIN_W   = clog2_min1(DRAIN_CYC);

  localparam logic [ADDR_W-1:0]  PIX_LAST   = ADDR_W'(NUM_OF_PIXELS - 1);
  localparam logic [IDX_W-1:0]   SV_LAST    = IDX_W'(NUM_OF_SV - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYC - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pix_addr_q, pix_addr_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [IDX_W-1:0]   k_idx_q, k_idx_d;
  logic               busy_q, busy_d;
  logic               rd_en_q, rd_en_d;
  logic               mac_clr_q, mac_clr_d;
  logic               shift_load_q, shift_load_d;
  logic               k_valid_q, k_valid_d;
  logic               done_q, done_d;
  logic               fetch_last;
  logic [1:0]         strobe_dly;

  // Accept is combinational so the head can advance in the same cycle.
  assign shift_en = k_valid_q & k_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_FETCH;
      S_FETCH: if (pix_addr_q == PIX_LAST) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == '0) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (shift_en && (k_idx_q == SV_LAST)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/counter logic: decoded from the next state so every strobe is
  // registered yet still lines up with the state it belongs to.
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    mac_clr_d    = (state_d == S_CLEAR);
    rd_en_d      = (state_d == S_FETCH);
    shift_load_d = (state_d == S_LOAD);
    k_valid_d    = (state_d == S_SHIFT);
    done_d       = (state_d == S_DONE);

    // Pixel index starts at 0 on FETCH entry and is parked at 0 otherwise.
    pix_addr_d = '0;
    if ((state_q == S_FETCH) && (state_d == S_FETCH))
      pix_addr_d = pix_addr_q + ADDR_W'(1);

    drain_d = '0;
    if (state_d == S_DRAIN)
      drain_d = (state_q == S_DRAIN) ? drain_q - DRAIN_W'(1) : DRAIN_INIT;

    k_idx_d = '0;
    if ((state_q == S_SHIFT) && (state_d == S_SHIFT))
      k_idx_d = shift_en ? k_idx_q + IDX_W'(1) : k_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_addr_q   <= '0;
      drain_q      <= '0;
      k_idx_q      <= '0;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      mac_clr_q    <= 1'b0;
      shift_load_q <= 1'b0;
      k_valid_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      pix_addr_q   <= pix_addr_d;
      drain_q      <= drain_d;
      k_idx_q      <= k_idx_d;
      busy_q       <= busy_d;
      rd_en_q      <= rd_en_d;
      mac_clr_q    <= mac_clr_d;
      shift_load_q <= shift_load_d;
      k_valid_q    <= k_valid_d;
      done_q       <= done_d;
    end
  end

  // The read strobe and its last-pixel qualifier travel together so that
  // mac_en/mac_last meet the pixel data coming out of the RAMs.
  assign fetch_last = rd_en_q & (pix_addr_q == PIX_LAST);

  valid_delay #(
    .DEPTH (RAM_LAT),
    .W     (2)
  ) u_valid_delay (
    .clk (clk),
    .rst (rst),
    .d_i ({rd_en_q, fetch_last}),
    .q_o (strobe_dly)
  );

  assign mac_en     = strobe_dly[1];
  assign mac_last   = strobe_dly[0];
  assign busy       = busy_q;
  assign rd_en      = rd_en_q;
  assign pix_addr   = pix_addr_q;
  assign mac_clr    = mac_clr_q;
  assign shift_load = shift_load_q;
  assign k_valid    = k_valid_q;
  assign k_idx      = k_idx_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_stage1_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_stage1_seq_ctrl                                               |
// | Self-checking bench for stage1_seq_ctrl. Instance a uses default           |
// | parameters, instance b a reduced geometry. Expected per-cycle output       |
// | snapshots are derived from the job timing and queued when stimulus is      |
// | driven, then popped and compared as each cycle is sampled.                 |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_stage1_seq_ctrl;

  typedef struct packed {
    logic       busy;
    logic       clr;
    logic       rd;
    logic [7:0] addr;
    logic       mac;
    logic       last;
    logic       load;
    logic       kv;
    logic [7:0] kidx;
    logic       sen;
    logic       done;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic k_ready_a = 1'b1, k_ready_b = 1'b1;

  logic       a_busy, a_rd_en, a_mac_clr, a_mac_en, a_mac_last, a_shift_load, a_shift_en, a_k_valid, a_done;
  logic [4:0] a_pix_addr;
  logic [3:0] a_k_idx;
  logic       b_busy, b_rd_en, b_mac_clr, b_mac_en, b_mac_last, b_shift_load, b_shift_en, b_k_valid, b_done;
  logic [1:0] b_pix_addr;
  logic [0:0] b_k_idx;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   clr_cnt_a = 0, mac_cnt_a = 0, sen_cnt_a = 0, mac_cnt_b = 0;
  bit   kr_stall = 1'b0;
  int   kr_s0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stage1_seq_ctrl dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .busy(a_busy), .rd_en(a_rd_en),
    .pix_addr(a_pix_addr), .mac_clr(a_mac_clr), .mac_en(a_mac_en), .mac_last(a_mac_last),
    .shift_load(a_shift_load), .shift_en(a_shift_en), .k_valid(a_k_valid),
    .k_ready(k_ready_a), .k_idx(a_k_idx), .done(a_done)
  );

  stage1_seq_ctrl #(
    .NUM_OF_PIXELS(4), .NUM_OF_SV(2), .RAM_LAT(2), .MAC_LAT(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .busy(b_busy), .rd_en(b_rd_en),
    .pix_addr(b_pix_addr), .mac_clr(b_mac_clr), .mac_en(b_mac_en), .mac_last(b_mac_last),
    .shift_load(b_shift_load), .shift_en(b_shift_en), .k_valid(b_k_valid),
    .k_ready(k_ready_b), .k_idx(b_k_idx), .done(b_done)
  );

  // Expected outputs in cycle r after the start-accept edge (r=1 is CLEAR).
  function automatic snap_t exp_snap(input int r, input int P, input int S,
                                     input int RL, input int ML, input bit stall);
    snap_t s;
    int    ld, s0, acc_last, dn;
    s        = '0;
    ld       = P + 2 + RL + ML;
    s0       = ld + 1;
    acc_last = stall ? s0 + 2 * S - 1 : s0 + S - 1;
    dn       = acc_last + 1;
    s.busy   = (r >= 1 && r <= dn);
    s.clr    = (r == 1);
    s.rd     = (r >= 2 && r <= P + 1);
    if (s.rd) s.addr = 8'(r - 2);
    s.mac    = (r >= 2 + RL && r <= P + 1 + RL);
    s.last   = (r == P + 1 + RL);
    s.load   = (r == ld);
    s.kv     = (r >= s0 && r <= acc_last);
    if (s.kv) begin
      s.kidx = stall ? 8'((r - s0) / 2) : 8'(r - s0);
      s.sen  = stall ? ((r - s0) % 2 == 1) : 1'b1;
    end
    s.done   = (r == dn);
    return s;
  endfunction

  task automatic push_job(input bit which, input int base, input int r_from, input int r_to,
                          input int P, input int S, input int RL, input int ML, input bit stall);
    exp_t e;
    for (int r = r_from; r <= r_to; r++) begin
      e.cyc = base + r;
      e.s   = exp_snap(r, P, S, RL, ML, stall);
      if (which) qb.push_back(e);
      else       qa.push_back(e);
    end
  endtask

  task automatic push_idle(input bit which, input int c_from, input int c_to);
    exp_t e;
    for (int c = c_from; c <= c_to; c++) begin
      e.cyc = c;
      e.s   = '0;
      if (which) qb.push_back(e);
      else       qa.push_back(e);
    end
  endtask

  // One clock: sample on the falling edge, pop the scoreboard, then move
  // to just after the next rising edge and drive k_ready.
  task automatic tick();
    snap_t act;
    exp_t  e;
    @(negedge clk);
    act = {a_busy, a_mac_clr, a_rd_en, 8'(a_pix_addr), a_mac_en, a_mac_last, a_shift_load,
           a_k_valid, 8'(a_k_idx), a_shift_en, a_done};
    clr_cnt_a += int'(a_mac_clr);
    mac_cnt_a += int'(a_mac_en);
    sen_cnt_a += int'(a_shift_en);
    mac_cnt_b += int'(b_mac_en);
    if (qa.size() > 0 && qa[0].cyc <= cyc) begin
      e = qa.pop_front();
      n_tests++;
      if (e.cyc != cyc || act !== e.s) begin
        n_fail++;
        $display("FAIL sb_a cyc %0d (exp for %0d): got %h required %h", cyc, e.cyc, act, e.s);
      end
    end
    act = {b_busy, b_mac_clr, b_rd_en, 8'(b_pix_addr), b_mac_en, b_mac_last, b_shift_load,
           b_k_valid, 8'(b_k_idx), b_shift_en, b_done};
    if (qb.size() > 0 && qb[0].cyc <= cyc) begin
      e = qb.pop_front();
      n_tests++;
      if (e.cyc != cyc || act !== e.s) begin
        n_fail++;
        $display("FAIL sb_b cyc %0d (exp for %0d): got %h required %h", cyc, e.cyc, act, e.s);
      end
    end
    @(posedge clk);
    #2;
    k_ready_a = kr_stall ? ((cyc - kr_s0) % 2 == 1) : 1'b1;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic test_reset();
    push_idle(1'b0, 1, 3);
    push_idle(1'b1, 1, 3);
    run_until(4);
    n_tests++;
    if ({a_busy, a_rd_en, a_mac_clr, a_mac_en, a_k_valid, a_done, a_shift_load, a_pix_addr, a_k_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got busy=%b rd=%b clr=%b mac=%b kv=%b done=%b required all 0",
               a_busy, a_rd_en, a_mac_clr, a_mac_en, a_k_valid, a_done);
    end
    n_tests++;
    if ({b_busy, b_rd_en, b_mac_clr, b_mac_en, b_k_valid, b_done, b_shift_load} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got busy=%b rd=%b clr=%b required 0", b_busy, b_rd_en, b_mac_clr);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    run_until(cyc + 2);
  endtask

  task automatic test_single_job();
    int base, m0;
    base = cyc;
    m0   = mac_cnt_a;
    start_a = 1'b1;
    push_job(1'b0, base, 1, 48, 30, 10, 1, 3, 1'b0);
    tick();
    start_a = 1'b0;
    run_until(base + 49);
    n_tests++;
    if (mac_cnt_a - m0 != 30) begin
      n_fail++;
      $display("FAIL single_mac_count: got %0d required 30", mac_cnt_a - m0);
    end
    n_tests++;
    if (qa.size() != 0) begin
      n_fail++;
      $display("FAIL single_pending: got %0d required 0", qa.size());
    end
  endtask

  task automatic test_ready_stall();
    int base, s0;
    base = cyc;
    s0 = sen_cnt_a;
    kr_stall = 1'b1;
    kr_s0 = base + 37;
    start_a = 1'b1;
    push_job(1'b0, base, 1, 58, 30, 10, 1, 3, 1'b1);
    tick();
    start_a = 1'b0;
    run_until(base + 59);
    kr_stall = 1'b0;
    n_tests++;
    if (sen_cnt_a - s0 != 10) begin
      n_fail++;
      $display("FAIL stall_shift_en_count: got %0d required 10", sen_cnt_a - s0);
    end
    n_tests++;
    if (qa.size() != 0) begin
      n_fail++;
      $display("FAIL stall_pending: got %0d required 0", qa.size());
    end
  endtask

  task automatic test_back_to_back();
    int base, c0, m0;
    base = cyc;
    c0 = clr_cnt_a;
    m0 = mac_cnt_a;
    start_a = 1'b1;
    push_job(1'b0, base, 1, 48, 30, 10, 1, 3, 1'b0);
    push_job(1'b0, base + 48, 1, 48, 30, 10, 1, 3, 1'b0);
    run_until(base + 96);
    start_a = 1'b0;
    push_idle(1'b0, base + 97, base + 98);
    run_until(base + 99);
    n_tests++;
    if (clr_cnt_a - c0 != 2) begin
      n_fail++;
      $display("FAIL b2b_clr_count: got %0d required 2", clr_cnt_a - c0);
    end
    n_tests++;
    if (mac_cnt_a - m0 != 60) begin
      n_fail++;
      $display("FAIL b2b_mac_count: got %0d required 60", mac_cnt_a - m0);
    end
    n_tests++;
    if (qa.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_pending: got %0d required 0", qa.size());
    end
  endtask

  task automatic test_reset_mid_fetch();
    int base, m0;
    base = cyc;
    start_a = 1'b1;
    push_job(1'b0, base, 1, 15, 30, 10, 1, 3, 1'b0);
    tick();
    start_a = 1'b0;
    run_until(base + 15);
    rst_a = 1'b1;
    start_a = 1'b1;
    push_idle(1'b0, base + 16, base + 20);
    run_until(base + 18);
    n_tests++;
    if ({a_busy, a_rd_en, a_mac_clr, a_mac_en, a_mac_last, a_k_valid, a_done, a_pix_addr} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got busy=%b rd=%b addr=%0d mac=%b required all 0",
               a_busy, a_rd_en, a_pix_addr, a_mac_en);
    end
    rst_a = 1'b0;
    start_a = 1'b0;
    m0 = mac_cnt_a;
    run_until(base + 21);
    n_tests++;
    if (mac_cnt_a != m0) begin
      n_fail++;
      $display("FAIL midrst_leak: got %0d mac_en pulses required 0", mac_cnt_a - m0);
    end
    test_single_job();
  endtask

  task automatic test_rst_and_start();
    int base;
    base = cyc;
    rst_a = 1'b1;
    start_a = 1'b1;
    push_idle(1'b0, base + 1, base + 5);
    run_until(base + 3);
    n_tests++;
    if (a_busy !== 1'b0 || a_mac_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_start_busy: got busy=%b clr=%b required 0 0", a_busy, a_mac_clr);
    end
    rst_a = 1'b0;
    start_a = 1'b0;
    run_until(base + 6);
    n_tests++;
    if (qa.size() != 0) begin
      n_fail++;
      $display("FAIL rst_start_pending: got %0d required 0", qa.size());
    end
  endtask

  task automatic test_small_params();
    int base, m0;
    base = cyc;
    m0 = mac_cnt_b;
    start_b = 1'b1;
    push_job(1'b1, base, 1, 13, 4, 2, 2, 1, 1'b0);
    tick();
    start_b = 1'b0;
    run_until(base + 14);
    n_tests++;
    if (mac_cnt_b - m0 != 4) begin
      n_fail++;
      $display("FAIL small_mac_count: got %0d required 4", mac_cnt_b - m0);
    end
    n_tests++;
    if (qb.size() != 0) begin
      n_fail++;
      $display("FAIL small_pending: got %0d required 0", qb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_ready_stall();
    test_back_to_back();
    test_reset_mid_fetch();
    test_rst_and_start();
    test_small_params();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
